// File: rtl/fifo_param_if.sv
// fifo_param_if: data/handshake bundle between a FIFO and its producer/consumer.
//   master : drives WRITE, DATA_IN, READ; observes data, flags, count, errors
//   slave  : the FIFO side; drives DATA_OUT, F_*_N flags, USE_DW, OVF, UDF
interface fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             WRITE;
    logic [WIDTH-1:0] DATA_IN;
    logic             READ;
    logic [WIDTH-1:0] DATA_OUT;
    logic             F_FULL_N;
    logic             F_EMPTY_N;
    logic             F_AFULL_N;
    logic             F_AEMPTY_N;
    logic [CW-1:0]    USE_DW;
    logic             OVF;
    logic             UDF;

    modport master (
        output WRITE, DATA_IN, READ,
        input  DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               USE_DW, OVF, UDF
    );

    modport slave (
        input  WRITE, DATA_IN, READ,
        output DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N,
               USE_DW, OVF, UDF
    );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with almost-full/almost-empty
// thresholds, simultaneous read+write when full, and sticky OVF/UDF flags.
//   CLOCK    rising-edge clock
//   RESET_N  synchronous reset, active low
//   CLEAR_N  synchronous flush, active low (same effect as reset)
//   fifo     slave side of fifo_param_if: WRITE/DATA_IN/READ in;
//            registered DATA_OUT, F_FULL_N, F_EMPTY_N, F_AFULL_N,
//            F_AEMPTY_N, USE_DW, OVF, UDF out
module fifo_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int AF_LVL = 28,
    parameter int AE_LVL = 4
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          CLEAR_N,
    fifo_param_if.slave   fifo
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             flush;

    assign flush = !RESET_N || !CLEAR_N;

    // Acceptance depends only on the current state: on EMPTY a read is
    // ignored even alongside a write; on FULL a write needs a paired read.
    always_comb begin
        wr_acc = 1'b0;
        rd_acc = 1'b0;
        unique case (state)
            EMPTY: begin
                wr_acc = fifo.WRITE;
            end
            PARTIAL: begin
                wr_acc = fifo.WRITE;
                rd_acc = fifo.READ;
            end
            FULL: begin
                rd_acc = fifo.READ;
                wr_acc = fifo.WRITE && fifo.READ;
            end
            default: begin
                wr_acc = 1'b0;
                rd_acc = 1'b0;
            end
        endcase
        count_nxt = count + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
    end

    // Storage is never cleared; only pointers and count are reset.
    always_ff @(posedge CLOCK) begin
        if (!flush && wr_acc) begin
            mem[wr_ptr] <= fifo.DATA_IN;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (flush) begin
            state           <= EMPTY;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            fifo.DATA_OUT   <= '0;
            fifo.F_FULL_N   <= 1'b1;
            fifo.F_EMPTY_N  <= 1'b0;
            fifo.F_AFULL_N  <= 1'b1;
            fifo.F_AEMPTY_N <= 1'b0;
            fifo.OVF        <= 1'b0;
            fifo.UDF        <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // When FULL, rd_ptr==wr_ptr: the memory read sees the old word.
            if (rd_acc) begin
                fifo.DATA_OUT <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end

            count           <= count_nxt;
            fifo.F_FULL_N   <= (count_nxt != CW'(DEPTH));
            fifo.F_EMPTY_N  <= (count_nxt != '0);
            fifo.F_AFULL_N  <= !(count_nxt >= CW'(AF_LVL));
            fifo.F_AEMPTY_N <= !(count_nxt <= CW'(AE_LVL));

            if (state == EMPTY && fifo.READ) begin
                fifo.UDF <= 1'b1;
            end
            if (state == FULL && fifo.WRITE && !fifo.READ) begin
                fifo.OVF <= 1'b1;
            end

            if (count_nxt == '0) begin
                state <= EMPTY;
            end else if (count_nxt == CW'(DEPTH)) begin
                state <= FULL;
            end else begin
                state <= PARTIAL;
            end
        end
    end

    assign fifo.USE_DW = count;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: drives fifo_param through directed scenarios and a random
// phase, comparing every output each cycle against a queue-based model.
module tb_fifo_param;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 32;
    localparam int AF_LVL = 28;
    localparam int AE_LVL = 4;

    logic clk;
    logic rst_n;
    logic clr_n;

    int unsigned vectors;
    int unsigned miscompares;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_udf;

    fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AF_LVL(AF_LVL),
        .AE_LVL(AE_LVL)
    ) dut (
        .CLOCK  (clk),
        .RESET_N(rst_n),
        .CLEAR_N(clr_n),
        .fifo   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model.
    task automatic model_edge();
        int unsigned n;
        logic was_full;
        logic was_empty;
        n = q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (!rst_n || !clr_n) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (bus.READ && was_empty) m_udf = 1'b1;
            if (bus.WRITE && was_full && !bus.READ) m_ovf = 1'b1;
            if (bus.READ && !was_empty) m_dout = q.pop_front();
            if (bus.WRITE && (!was_full || bus.READ)) q.push_back(bus.DATA_IN);
        end
    endtask

    task automatic check_all();
        int unsigned n;
        n = q.size();
        check("use_dw",   32'(bus.USE_DW),     n);
        check("data_out", 32'(bus.DATA_OUT),   32'(m_dout));
        check("full_n",   32'(bus.F_FULL_N),   32'(n != DEPTH));
        check("empty_n",  32'(bus.F_EMPTY_N),  32'(n != 0));
        check("afull_n",  32'(bus.F_AFULL_N),  32'(!(n >= AF_LVL)));
        check("aempty_n", 32'(bus.F_AEMPTY_N), 32'(!(n <= AE_LVL)));
        check("ovf",      32'(bus.OVF),        32'(m_ovf));
        check("udf",      32'(bus.UDF),        32'(m_udf));
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic clr);
        bus.WRITE   = w;
        bus.DATA_IN = d;
        bus.READ    = r;
        clr_n       = ~clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_dout      = '0;
        m_ovf       = 1'b0;
        m_udf       = 1'b0;
        rst_n       = 1'b0;
        clr_n       = 1'b1;
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        bus.DATA_IN = '0;

        // 1: reset, then read on empty sets UDF
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_on_empty", 32'(bus.UDF), 32'd1);

        // 2: fill 0x00..0x1F, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("drain_order", 32'(bus.DATA_OUT), i);
        end

        // 3: overflow while full; 0xAA must never appear
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", 32'(bus.OVF), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 4: simultaneous read+write while full
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_rw_oldest", 32'(bus.DATA_OUT), 32'h80);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("full_rw_last", 32'(bus.DATA_OUT), 32'h55);

        // 5: wrap with interleaved pairs at low occupancy
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 6: clear mid-fill with a concurrent write
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        check("clear_use_dw", 32'(bus.USE_DW), 32'd0);
        check("clear_udf", 32'(bus.UDF), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random phase with varying read/write bias
        for (int blk = 0; blk < 16; blk++) begin
            int unsigned wp;
            int unsigned rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 99) < wp, 8'($urandom),
                         $urandom_range(0, 99) < rp,
                         $urandom_range(0, 149) == 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
